verificador_compuertas: RTL and testbench

Hardware self-test controller, the active counterpart of the gate block's stimulus/response path. It drives the X/Y inputs of a Compuertas_Logicas instance through all four input combinations. It samples the six gate outputs after a settle window and compares them against internally computed expected values. It reports pass/fail, a mismatch count and a per-vector failure mask. It sits beside the gate block on the board-level top and is started by a push-button or a host strobe.

---
 rtl/verificador_pkg.sv | 19 +
 rtl/verificador_compuertas_modelo.sv | 12 +
 rtl/verificador_compuertas.sv | 145 ++++++++++++++
 tb/tb_verificador_compuertas.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/verificador_pkg.sv
// Shared types, constants and the gate truth function for the gate-block self-test.
package verificador_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int NUM_VECTORS = 4;
   localparam int NUM_GATES   = 6;

   // Expected gate outputs packed as {NOR, XOR, NAND, NOT, OR, AND}.
   function automatic logic [NUM_GATES-1:0] expected_gates(input logic x, input logic y);
      return {~(x | y), x ^ y, ~(x & y), ~x, x | y, x & y};
   endfunction

endpackage

// File: rtl/verificador_compuertas_modelo.sv
// Combinational golden model of the gate block, also usable from a bench scoreboard.
module modelo_compuertas_ref
   import verificador_pkg::*;
(
   input  logic                 x,
   input  logic                 y,
   output logic [NUM_GATES-1:0] expected
);

   assign expected = expected_gates(x, y);

endmodule

// File: rtl/verificador_compuertas.sv
// Self-test sweep controller for the logic-gate block.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start after reset, all outputs at 0
// SETTLE | current vector driven on X/Y, waiting SETTLE_CYCLES cycles
// CHECK  | one cycle: compare gate outputs, accumulate errors, advance
// DONE   | results held until the next start or reset
module verificador_compuertas
   import verificador_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   X_out,
   output logic                   Y_out,
   input  logic                   Sand_in,
   input  logic                   Sor_in,
   input  logic                   Snot_in,
   input  logic                   Snand_in,
   input  logic                   Sxor_in,
   input  logic                   Snor_in,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [4:0]             err_count,
   output logic [NUM_VECTORS-1:0] fail_mask
);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("SETTLE_CYCLES must be in 1..15");
   end

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

   state_t                 state;
   state_t                 state_nxt;
   logic [1:0]             vec_idx;
   logic [1:0]             vec_nxt;
   logic [3:0]             settle_cnt;
   logic                   settle_done;
   logic [NUM_GATES-1:0]   expected;
   logic [NUM_GATES-1:0]   observed;
   logic [NUM_GATES-1:0]   mismatch;
   logic [2:0]             mismatch_cnt;
   logic [4:0]             err_sum;

   // Expected values come from the registered X/Y, so the compare sees a stable reference.
   modelo_compuertas_ref u_ref (
      .x        (X_out),
      .y        (Y_out),
      .expected (expected)
   );

   assign observed    = {Snor_in, Sxor_in, Snand_in, Snot_in, Sor_in, Sand_in};
   assign mismatch    = observed ^ expected;
   assign settle_done = (settle_cnt == SETTLE_LAST);
   assign vec_nxt     = vec_idx + 2'd1;
   assign err_sum     = err_count + {2'b00, mismatch_cnt};

   // Popcount of the per-gate mismatches for the current vector.
   always_comb begin
      mismatch_cnt = '0;
      for (int i = 0; i < NUM_GATES; i++) begin
         mismatch_cnt = mismatch_cnt + {2'b00, mismatch[i]};
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; start is only honoured when no sweep is running.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = SETTLE;
         SETTLE:     if (settle_done) state_nxt = CHECK;
         CHECK:      state_nxt = (vec_idx == LAST_VEC) ? DONE : SETTLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Vector sequencing, settle timing and result accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         X_out      <= 1'b0;
         Y_out      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_mask  <= '0;
         vec_idx    <= '0;
         settle_cnt <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_mask  <= '0;
                  vec_idx    <= '0;
                  X_out      <= 1'b0;
                  Y_out      <= 1'b0;
                  settle_cnt <= '0;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 4'd1;
            end
            CHECK: begin
               err_count  <= err_sum;
               settle_cnt <= '0;
               if (mismatch_cnt != 3'd0) begin
                  fail_mask[vec_idx] <= 1'b1;
               end
               if (vec_idx != LAST_VEC) begin
                  vec_idx <= vec_nxt;
                  X_out   <= vec_nxt[0];
                  Y_out   <= vec_nxt[1];
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_sum == 5'd0);
                  X_out <= 1'b0;
                  Y_out <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_verificador_compuertas.sv
module tb_verificador_compuertas;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       start_b = 1'b0;
   int         fault_mode = 0;   // 0 good, 1 XOR stuck-0, 2 NOT=Y, 3 NOT=X

   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   // ---------------- main DUT, default settle ----------------
   logic       x_m, y_m;
   logic       sand_m, sor_m, snot_m, snand_m, sxor_m, snor_m;
   logic       busy_m, done_m, pass_m;
   logic [4:0] err_m;
   logic [3:0] mask_m;

   verificador_compuertas dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .X_out(x_m), .Y_out(y_m),
      .Sand_in(sand_m), .Sor_in(sor_m), .Snot_in(snot_m),
      .Snand_in(snand_m), .Sxor_in(sxor_m), .Snor_in(snor_m),
      .busy(busy_m), .done(done_m), .pass(pass_m),
      .err_count(err_m), .fail_mask(mask_m)
   );

   // Gate block with selectable faults.
   always_comb begin
      sand_m  = x_m & y_m;
      sor_m   = x_m | y_m;
      snot_m  = ~x_m;
      snand_m = ~(x_m & y_m);
      sxor_m  = x_m ^ y_m;
      snor_m  = ~(x_m | y_m);
      if (fault_mode == 1) sxor_m = 1'b0;
      if (fault_mode == 2) snot_m = y_m;
      if (fault_mode == 3) snot_m = x_m;
   end

   // ---------------- delayed gate block DUTs ----------------
   logic       x5, y5, x1, y1;
   logic [3:0] px5, py5, px1, py1;
   logic       busy5, done5, pass5, busy1, done1, pass1;
   logic [4:0] err5, err1;
   logic [3:0] mask5, mask1;
   logic       a5, b5, a1, b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px5 <= '0; py5 <= '0; px1 <= '0; py1 <= '0;
      end else begin
         px5 <= {px5[2:0], x5}; py5 <= {py5[2:0], y5};
         px1 <= {px1[2:0], x1}; py1 <= {py1[2:0], y1};
      end
   end
   assign a5 = px5[3];
   assign b5 = py5[3];
   assign a1 = px1[3];
   assign b1 = py1[3];

   verificador_compuertas #(.SETTLE_CYCLES(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .X_out(x5), .Y_out(y5),
      .Sand_in(a5 & b5), .Sor_in(a5 | b5), .Snot_in(~a5),
      .Snand_in(~(a5 & b5)), .Sxor_in(a5 ^ b5), .Snor_in(~(a5 | b5)),
      .busy(busy5), .done(done5), .pass(pass5),
      .err_count(err5), .fail_mask(mask5)
   );

   verificador_compuertas #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .X_out(x1), .Y_out(y1),
      .Sand_in(a1 & b1), .Sor_in(a1 | b1), .Snot_in(~a1),
      .Snand_in(~(a1 & b1)), .Sxor_in(a1 ^ b1), .Snor_in(~(a1 | b1)),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_mask(mask1)
   );

   // ---------------- standalone golden model ----------------
   logic       tx, ty;
   logic [5:0] ref_exp;

   modelo_compuertas_ref u_ref (.x(tx), .y(ty), .expected(ref_exp));

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [1:0] xy_log [0:63];
   logic       busy_log [0:63];

   // Pulses start (edge 0), then counts edges until done; optional extra start at edge pulse_at.
   task automatic run_main(input int pulse_at, output int n);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      xy_log[0] = {x_m, y_m};
      busy_log[0] = busy_m;
      while (n < 60) begin
         @(posedge clk);
         n++;
         #1;
         xy_log[n] = {x_m, y_m};
         busy_log[n] = busy_m;
         if (done_m) break;
         start = (n == pulse_at);
      end
      start = 1'b0;
      if (!done_m) check("run_main_timeout", 32'(done_m), 32'd1);
   endtask

   task automatic check_results(input string tag, input int n, input logic p,
                                input logic [4:0] e, input logic [3:0] m);
      check({tag, "_latency"}, 32'(n), 32'd12);
      check({tag, "_pass"}, 32'(pass_m), 32'(p));
      check({tag, "_err"}, 32'(err_m), 32'(e));
      check({tag, "_mask"}, 32'(mask_m), 32'(m));
      check({tag, "_busy"}, 32'(busy_m), 32'd0);
      check({tag, "_xy"}, 32'({x_m, y_m}), 32'd0);
   endtask

   localparam logic [5:0] REF_TBL [0:3] = '{6'b101100, 6'b011010, 6'b011110, 6'b000011};

   initial begin : stim
      int n;
      int n5;
      int n1;

      // golden model table, v = {Y,X}
      for (int v = 0; v < 4; v++) begin
         tx = v[0];
         ty = v[1];
         #1;
         check($sformatf("ref_v%0d", v), 32'(ref_exp), 32'(REF_TBL[v]));
      end

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", 32'({x_m, y_m, busy_m, done_m, pass_m, err_m, mask_m}), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_no_activity", 32'({busy_m, done_m}), 32'd0);

      // good gate block
      fault_mode = 0;
      run_main(-1, n);
      check_results("good", n, 1'b1, 5'd0, 4'b0000);
      check("good_xy_v0", 32'(xy_log[0]), 32'b00);
      check("good_xy_v1", 32'(xy_log[3]), 32'b10);
      check("good_xy_v2", 32'(xy_log[6]), 32'b01);
      check("good_xy_v3", 32'(xy_log[9]), 32'b11);
      check("good_busy_e0", 32'(busy_log[0]), 32'd1);
      check("good_busy_e11", 32'(busy_log[11]), 32'd1);

      // XOR stuck at 0, with a start pulse mid-sweep that must be ignored
      repeat (2) @(posedge clk);
      #1 fault_mode = 1;
      run_main(5, n);
      check_results("xor_sa0", n, 1'b0, 5'd2, 4'b0110);

      // restart from DONE clears results on that edge
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("restart_done", 32'(done_m), 32'd0);
      check("restart_busy", 32'(busy_m), 32'd1);
      check("restart_err", 32'(err_m), 32'd0);
      check("restart_mask", 32'(mask_m), 32'd0);
      repeat (12) @(posedge clk);
      #1;
      check("restart_done12", 32'(done_m), 32'd1);
      check("restart_err12", 32'(err_m), 32'd2);

      // NOT output wired to Y: mismatches only where ~X != Y, i.e. vectors 0 and 3
      #1 fault_mode = 2;
      run_main(-1, n);
      check_results("not_eq_y", n, 1'b0, 5'd2, 4'b1001);

      // NOT output wired to X: wrong on every vector
      #1 fault_mode = 3;
      run_main(-1, n);
      check_results("not_eq_x", n, 1'b0, 5'd4, 4'b1111);

      // async reset during SETTLE of vector 2
      #1 fault_mode = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("pre_rst_xy", 32'({x_m, y_m}), 32'b01);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst", 32'({x_m, y_m, busy_m, done_m, pass_m, err_m, mask_m}), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_idle", 32'({x_m, y_m, busy_m, done_m, err_m}), 32'd0);

      // delayed gate block: 5-cycle settle passes, 1-cycle settle fails
      start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
      n = 0;
      n5 = -1;
      n1 = -1;
      while (n < 60 && (n5 < 0 || n1 < 0)) begin
         @(posedge clk);
         n++;
         #1;
         if (done5 && n5 < 0) n5 = n;
         if (done1 && n1 < 0) n1 = n;
      end
      check("s5_latency", 32'(n5), 32'd24);
      check("s5_pass", 32'(pass5), 32'd1);
      check("s5_err", 32'(err5), 32'd0);
      check("s1_latency", 32'(n1), 32'd8);
      check("s1_pass", 32'(pass1), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
